// File: rtl/noc_pkg.sv
`default_nettype none
// =============================================================================
// Module   : noc_pkg
// Purpose  : Shared defaults and the transmitter state type for the NoC output port.
// Revision : 1.0
// =============================================================================
package noc_pkg;

    localparam int c_DATA_W  = 16;
    localparam int c_DEPTH   = 4;
    localparam int c_CREDITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } tx_state_t;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// =============================================================================
// Module   : tx_fifo
// Purpose  : Power-of-two circular buffer with occupancy count; head is read combinationally.
// Revision : 1.0
// =============================================================================
module tx_fifo
    import noc_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_CW-1:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + c_PW'(1);
            if (i_pop)  r_rptr <= r_rptr + c_PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule : tx_fifo
`default_nettype wire

// File: rtl/output_tx.sv
`default_nettype none
// =============================================================================
// Module   : output_tx
// Purpose  : Credit-based NoC output port: local FIFO, credit counter, send FSM, output register.
// Revision : 1.0
// =============================================================================
module output_tx
    import noc_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int DEPTH   = c_DEPTH,
    parameter int CREDITS = c_CREDITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         credit_i,
    output logic                         valid_o,
    output logic [DATA_W-1:0]            data_o,
    output logic [$clog2(CREDITS+1)-1:0] credit_cnt_o,
    output logic                         err_o
);

    localparam int c_CW  = $clog2(DEPTH+1);
    localparam int c_CRW = $clog2(CREDITS+1);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [c_CRW-1:0]  r_credits;
    logic [c_CRW-1:0]  w_credits_nxt;
    logic [c_CW-1:0]   w_count;
    logic [c_CW-1:0]   w_count_nxt;
    logic [DATA_W-1:0] w_head;
    logic              w_ready;
    logic              w_push;
    logic              w_send;
    logic              w_credit_ovf;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_err;

    assign w_ready      = rst && (w_count < c_CW'(DEPTH));
    assign w_push       = valid_i && w_ready;
    assign w_send       = (r_state == SEND);
    assign w_credit_ovf = credit_i && !w_send && (r_credits == c_CRW'(CREDITS));
    assign w_count_nxt  = w_count + c_CW'(w_push) - c_CW'(w_send);

    tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (data_i),
        .i_pop   (w_send),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_comb begin
        w_credits_nxt = r_credits;
        if (w_send && !credit_i)
            w_credits_nxt = r_credits - c_CRW'(1);
        else if (credit_i && !w_send && !w_credit_ovf)
            w_credits_nxt = r_credits + c_CRW'(1);
    end

    // Next state follows next-cycle occupancy and credits, so SEND always means "may pop now".
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_push)
                    w_state_nxt = (w_credits_nxt != '0) ? SEND : STALL;
            end
            SEND: begin
                if (w_count_nxt == '0)
                    w_state_nxt = IDLE;
                else if (w_credits_nxt == '0)
                    w_state_nxt = STALL;
            end
            STALL: begin
                if (w_count_nxt == '0)
                    w_state_nxt = IDLE;
                else if (w_credits_nxt != '0)
                    w_state_nxt = SEND;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_credits <= c_CRW'(CREDITS);
        end else begin
            r_state   <= w_state_nxt;
            r_credits <= w_credits_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_send;
            if (w_send) r_data <= w_head;
            if (w_credit_ovf) r_err <= 1'b1;
        end
    end

    assign ready_o      = w_ready;
    assign valid_o      = r_valid;
    assign data_o       = r_data;
    assign credit_cnt_o = r_credits;
    assign err_o        = r_err;

endmodule : output_tx
`default_nettype wire

// File: tb/tb_output_tx.sv
`default_nettype none
// =============================================================================
// Module   : tb_output_tx
// Purpose  : Scoreboard bench for output_tx with a queue-based reference model.
// Revision : 1.0
// =============================================================================
module tb_output_tx;

    localparam int c_DEPTH   = 4;
    localparam int c_CREDITS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic        credit_i;
    logic        valid_o;
    logic [15:0] data_o;
    logic [2:0]  credit_cnt_o;
    logic        err_o;

    always #5 clk = ~clk;

    output_tx dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .credit_i     (credit_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .credit_cnt_o (credit_cnt_o),
        .err_o        (err_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: buffered flits, credits, and the expected output stream.
    int mq[$];
    int exp_q[$];
    int m_cred  = c_CREDITS;
    bit m_valid = 1'b0;
    bit m_err   = 1'b0;
    int m_last  = 0;
    bit m_snd;
    bit m_acc;
    int n_seen  = 0;
    bit mon_en  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            exp_q.delete();
            m_cred  = c_CREDITS;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_last  = 0;
        end else begin
            m_snd   = (mq.size() > 0) && (m_cred > 0);
            m_acc   = valid_i && (mq.size() < c_DEPTH);
            m_valid = m_snd;
            if (m_snd) begin
                m_last = mq.pop_front();
                exp_q.push_back(m_last);
            end
            if (m_acc) mq.push_back(int'(data_i));
            if (m_snd && !credit_i)
                m_cred--;
            else if (credit_i && !m_snd) begin
                if (m_cred == c_CREDITS) m_err = 1'b1;
                else m_cred++;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("ready", {31'd0, ready_o}, {31'd0, (rst && mq.size() < c_DEPTH)});
            check("credit_cnt", {29'd0, credit_cnt_o}, m_cred);
            check("err", {31'd0, err_o}, {31'd0, m_err});
            check("valid", {31'd0, valid_o}, {31'd0, m_valid});
            check("data_hold", {16'd0, data_o}, m_last);
            if (valid_o === 1'b1) begin
                n_seen++;
                if (exp_q.size() == 0)
                    check("sb_unexpected_flit", {16'd0, data_o}, 32'hFFFF_FFFF);
                else
                    check("sb_data", {16'd0, data_o}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int s0;

    initial begin
        rst = 1'b0; valid_i = 1'b0; credit_i = 1'b0; data_i = '0;
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_valid", {31'd0, valid_o}, 0);
        check("rst_credits", {29'd0, credit_cnt_o}, 4);
        check("rst_ready", {31'd0, ready_o}, 0);
        check("rst_err", {31'd0, err_o}, 0);
        rst = 1'b1;
        tick();

        // Single flit: two-cycle latency.
        valid_i = 1'b1; data_i = 16'hA5A5;
        tick();
        valid_i = 1'b0;
        tick();
        check("single_valid", {31'd0, valid_o}, 1);
        check("single_data", {16'd0, data_o}, 32'hA5A5);
        check("single_credits", {29'd0, credit_cnt_o}, 3);
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        tick();

        // Credit exhaustion with six back-to-back flits.
        s0 = n_seen;
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1; data_i = 16'(16'h1000 + i);
            tick();
        end
        valid_i = 1'b0;
        repeat (4) tick();
        check("exh_sends", n_seen - s0, 4);
        check("exh_credits", {29'd0, credit_cnt_o}, 0);
        check("exh_ready", {31'd0, ready_o}, 1);

        // Credit return releases flits five and six.
        for (int i = 0; i < 2; i++) begin
            credit_i = 1'b1;
            tick();
            credit_i = 1'b0;
            tick();
        end
        repeat (3) tick();
        check("ret_sends", n_seen - s0, 6);
        check("ret_last_data", {16'd0, data_o}, 32'h1005);

        // Full FIFO with no credits: fifth flit dropped.
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; data_i = 16'(16'h2000 + i);
            tick();
        end
        valid_i = 1'b0;
        tick();
        check("full_ready", {31'd0, ready_o}, 0);

        // Simultaneous send and credit, then overflow.
        credit_i = 1'b1;
        tick();
        tick();
        check("simul_credits", {29'd0, credit_cnt_o}, 1);
        check("simul_valid", {31'd0, valid_o}, 1);
        tick();
        tick();
        credit_i = 1'b0;
        tick();
        tick();
        check("simul_drained", {16'd0, data_o}, 32'h2003);
        for (int i = 0; i < 4; i++) begin
            credit_i = 1'b1;
            tick();
            credit_i = 1'b0;
            tick();
        end
        check("ovf_pre_err", {31'd0, err_o}, 0);
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        tick();
        check("ovf_err", {31'd0, err_o}, 1);
        check("ovf_credits", {29'd0, credit_cnt_o}, 4);

        // Mid-operation reset with three flits buffered.
        for (int i = 0; i < 7; i++) begin
            valid_i = 1'b1; data_i = 16'(16'h3000 + i);
            tick();
        end
        valid_i = 1'b0;
        tick();
        check("mid_credits0", {29'd0, credit_cnt_o}, 0);
        rst = 1'b0;
        tick();
        check("mid_valid", {31'd0, valid_o}, 0);
        check("mid_credits", {29'd0, credit_cnt_o}, 4);
        check("mid_ready", {31'd0, ready_o}, 0);
        check("mid_err", {31'd0, err_o}, 0);
        rst = 1'b1;
        tick();
        check("mid_release_ready", {31'd0, ready_o}, 1);
        s0 = n_seen;
        repeat (5) tick();
        check("mid_no_stale", n_seen - s0, 0);

        // Randomized traffic, credit returns and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            valid_i  = ($urandom_range(0, 99) < 70);
            data_i   = 16'($urandom);
            credit_i = ($urandom_range(0, 99) < 35);
            rst      = !($urandom_range(0, 199) == 0);
            tick();
        end
        valid_i = 1'b0; credit_i = 1'b0; rst = 1'b1;
        repeat (10) tick();
        check("sb_leftover", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_output_tx
`default_nettype wire

// File: doc/output_tx.md
OUTPUT_TX -- requirements
Module: output_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, local FIFO entries (power of two).
REQ-003 SHALL have parameter CREDITS, default 4, downstream input-queue depth.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port data_i, input, DATA_W, flit from the crossbar.
REQ-007 SHALL have port valid_i, input, 1, data_i qualifier.
REQ-008 SHALL have port ready_o, output, 1, FIFO can accept a flit this cycle.
REQ-009 SHALL have port credit_i, input, 1, one-cycle pulse when the downstream queue pops one flit.
REQ-010 SHALL have port valid_o, output, 1, flit on data_o is valid for exactly this cycle.
REQ-011 SHALL have port data_o, output, DATA_W, flit to the downstream input queue.
REQ-012 SHALL have port credit_cnt_o, output, $clog2(CREDITS+1), current credit count.
REQ-013 SHALL have port err_o, output, 1, sticky credit-overflow flag.

Function
REQ-014 SHALL push data_i into the FIFO on a cycle where valid_i && ready_o; valid_i with ready_o low is ignored (no push).
REQ-015 SHALL drive ready_o = (count < DEPTH) from registered count, with no same-cycle bypass when full.
REQ-016 SHALL keep count in 0..DEPTH; on simultaneous push and pop, count is unchanged; read/write pointers wrap modulo DEPTH.
REQ-017 SHALL send when FIFO is non-empty and credit count > 0: pop the head, register it onto data_o, and assert valid_o in the next cycle.
REQ-018 SHALL give a minimum latency of 2 cycles (flit accepted in cycle N appears on valid_o in cycle N+2) when the FIFO was empty and credits > 0.
REQ-019 SHALL sustain one flit per cycle while credits are available.
REQ-020 SHALL hold data_o at its last value with valid_o low in non-send cycles.
REQ-021 SHALL decrement credits on a send and increment them on credit_i; when both occur in the same cycle, credits are unchanged.
REQ-022 SHALL ignore credit_i when credits == CREDITS and no send occurs in that cycle, leaving credits at CREDITS and setting err_o until reset.
REQ-023 SHALL implement FSM states IDLE (FIFO empty), SEND (non-empty, credits > 0) and STALL (non-empty, credits == 0).
REQ-024 SHALL make these FSM transitions:
- IDLE->SEND on push with credits > 0.
- IDLE->STALL on push with credits == 0.
- SEND->STALL when the last credit is consumed and the FIFO is still non-empty.
- STALL->SEND on credit_i.
- Any state->IDLE when the FIFO becomes empty.

Reset
REQ-025 SHALL, while rst == 0 at a clock edge, clear count and pointers, set credits = CREDITS, state = IDLE, valid_o = 0, data_o = 0 and err_o = 0.
REQ-026 SHALL hold ready_o = 0 while rst == 0.
REQ-027 SHALL discard buffered flits and any in-flight send when reset is asserted mid-operation; a push or credit_i in a reset cycle has no effect.

Structure
REQ-028 SHALL take DATA_W, DEPTH and CREDITS defaults, and the tx_state_t enum (IDLE, SEND, STALL), from the shared package noc_pkg.
REQ-029 SHALL contain one sub-module, tx_fifo (storage, pointers, count); the credit counter, FSM and output register reside in output_tx.

Verification
REQ-030 SHALL cover single flit: reset, then push 0xA5A5 in cycle 0 -> valid_o = 1, data_o = 0xA5A5 in cycle 2; credit_cnt_o = 3.
REQ-031 SHALL cover credit exhaustion: push 6 flits back-to-back with no credit_i -> exactly 4 sends; state = STALL; credit_cnt_o = 0; ready_o stays 1 while count < 4.
REQ-032 SHALL cover credit return: from the REQ-031 end state, pulse credit_i twice -> the 5th and 6th flits are sent in order; FIFO empty; state = IDLE.
REQ-033 SHALL cover full FIFO: credits = 0 and 4 flits buffered -> ready_o = 0; a 5th valid_i is dropped; count stays 4.
REQ-034 SHALL cover simultaneous events: a send and credit_i in the same cycle -> credit_cnt_o unchanged; credit_i at credits = 4 with no send -> err_o = 1.
REQ-035 SHALL cover mid-operation reset: rst = 0 with 3 flits buffered -> next cycle valid_o = 0, credit_cnt_o = 4, ready_o = 0; after release, ready_o = 1 and no stale flits appear on data_o.
